// File: rtl/cordic_iter_sequencer.sv
// Control sequencer for an iterative CORDIC datapath: one load strobe, ITERATIONS
// micro-rotation steps with the atan ROM index, then a done pulse and sticky result flag.
module cordic_iter_sequencer #(
  parameter int ITERATIONS = 9,
  parameter int IDX_W      = $clog2(ITERATIONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_in,
  input  logic             clear,
  output logic             mode,
  output logic             load_en,
  output logic             step_en,
  output logic [IDX_W-1:0] iter_idx,
  output logic             busy,
  output logic             done,
  output logic             result_vld
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITERATIONS - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             mode_nxt;
  logic             rv, rv_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      rv    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
      rv    <= rv_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    rv_nxt    = rv;
    load_en   = 1'b0;
    step_en   = 1'b0;
    iter_idx  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          mode_nxt  = mode_in;
          rv_nxt    = 1'b0;
        end
      end
      LOAD: begin
        load_en   = 1'b1;
        busy      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ITER;
      end
      ITER: begin
        step_en  = 1'b1;
        busy     = 1'b1;
        iter_idx = cnt;
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          rv_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back start skips IDLE entirely.
        if (start) begin
          state_nxt = LOAD;
          mode_nxt  = mode_in;
          rv_nxt    = 1'b0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides any start; mode deliberately keeps its last captured value.
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      rv_nxt    = 1'b0;
      mode_nxt  = mode;
    end
  end

  assign result_vld = rv;

endmodule

// File: tb/tb_cordic_iter_sequencer.sv
// Bench for cordic_iter_sequencer: directed table, corner sequences and random stimulus
// against a cycles-since-start reference model; a second instance covers ITERATIONS=2.
module tb_cordic_iter_sequencer;
  localparam int N  = 9;
  localparam int W  = $clog2(N);
  localparam int N2 = 2;

  logic clk = 0, rst_n = 0, start = 0, mode_in = 0, clear = 0;
  logic mode, load_en, step_en, busy, done, result_vld;
  logic [W-1:0] iter_idx;
  logic mode2, load2, step2, busy2, done2, rv2;
  logic [0:0] idx2;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  cordic_iter_sequencer #(.ITERATIONS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .clear(clear),
    .mode(mode), .load_en(load_en), .step_en(step_en), .iter_idx(iter_idx),
    .busy(busy), .done(done), .result_vld(result_vld));

  cordic_iter_sequencer #(.ITERATIONS(N2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .clear(clear),
    .mode(mode2), .load_en(load2), .step_en(step2), .iter_idx(idx2),
    .busy(busy2), .done(done2), .result_vld(rv2));

  // Reference: a run is tracked by its age in cycles since the accepted start
  // (1 = load, 2..N+1 = steps, N+2 = done).
  bit   m_act;
  int   m_age;
  logic m_mode, m_rv;

  task automatic model_reset();
    m_act = 0; m_age = 0; m_mode = 0; m_rv = 0;
  endtask

  task automatic model_update(input logic s, input logic mi, input logic c);
    bit can_start;
    can_start = !m_act || (m_age == N + 2);
    if (c) begin
      m_act = 0; m_rv = 0;
    end else if (can_start && s) begin
      m_act = 1; m_age = 1; m_mode = mi; m_rv = 0;
    end else if (m_act && m_age == N + 2) begin
      m_act = 0;
    end else if (m_act) begin
      m_age++;
      if (m_age == N + 2) m_rv = 1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit st;
    st = m_act && m_age >= 2 && m_age <= N + 1;
    chk("load_en", int'(load_en), int'(m_act && m_age == 1));
    chk("step_en", int'(step_en), int'(st));
    chk("iter_idx", int'(iter_idx), st ? m_age - 2 : 0);
    chk("done", int'(done), int'(m_act && m_age == N + 2));
    chk("busy", int'(busy), int'(m_act && m_age <= N + 1));
    chk("result_vld", int'(result_vld), int'(m_rv));
    chk("mode", int'(mode), int'(m_mode));
  endtask

  task automatic step(input logic s, input logic mi, input logic c);
    start = s; mode_in = mi; clear = c;
    @(posedge clk);
    model_update(s, mi, c);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; clear = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  typedef struct {
    logic s, mi, c;
    logic ld, st; int idx; logic dn, bz, rv, md;
  } vec_t;

  function automatic vec_t mkv(logic s, logic mi, logic c, logic ld, logic st, int idx,
                               logic dn, logic bz, logic rv, logic md);
    vec_t v;
    v.s = s; v.mi = mi; v.c = c; v.ld = ld; v.st = st; v.idx = idx;
    v.dn = dn; v.bz = bz; v.rv = rv; v.md = md;
    return v;
  endfunction

  vec_t tbl[14];
  int   nsteps, ndone;

  initial begin
    // Single run, then back-to-back start on the done cycle.
    tbl[0] = mkv(1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < N; k++) tbl[1 + k] = mkv(0, 1, 0, 0, 1, k, 0, 1, 0, 0);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    tbl[11] = mkv(1, 1, 0, 1, 0, 0, 0, 1, 0, 1);
    tbl[12] = mkv(0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    tbl[13] = mkv(0, 0, 0, 0, 1, 1, 0, 1, 0, 1);

    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].s, tbl[i].mi, tbl[i].c);
      chk("tbl_load", int'(load_en), int'(tbl[i].ld));
      chk("tbl_step", int'(step_en), int'(tbl[i].st));
      chk("tbl_idx", int'(iter_idx), tbl[i].idx);
      chk("tbl_done", int'(done), int'(tbl[i].dn));
      chk("tbl_busy", int'(busy), int'(tbl[i].bz));
      chk("tbl_rv", int'(result_vld), int'(tbl[i].rv));
      chk("tbl_mode", int'(mode), int'(tbl[i].md));
    end

    // Async reset mid-ITER (mode is 1 here): everything drops immediately.
    step(0, 0, 0);
    rst_n = 0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step_en), 0);
    chk("rst_mode", int'(mode), 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1;
    step(0, 0, 0);

    // start pulses while iter_idx is 3 and 7 are ignored.
    step(1, 0, 0);
    nsteps = 0; ndone = 0;
    for (int j = 1; j <= 12; j++) begin
      step(j == 5 || j == 9, 0, 0);
      nsteps += int'(step_en);
      ndone  += int'(done);
    end
    chk("ign_steps", nsteps, N);
    chk("ign_done", ndone, 1);

    // clear with start at iter_idx 5 aborts, no restart.
    step(1, 0, 0);
    for (int j = 1; j <= 6; j++) step(0, 0, 0);
    chk("pre_clr_idx", int'(iter_idx), 5);
    step(1, 1, 1);
    chk("clr_busy", int'(busy), 0);
    chk("clr_rv", int'(result_vld), 0);
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      step(0, 0, 0);
      ndone += int'(done) + int'(load_en);
    end
    chk("clr_quiet", ndone, 0);

    // mode captured at start, mode_in toggled mid-run has no effect.
    step(1, 1, 0);
    for (int j = 1; j <= 10; j++) begin
      step(0, logic'(j % 2), 0);
      chk("mode_hold", int'(mode), 1);
    end
    step(0, 0, 0);
    chk("mode_idle", int'(mode), 1);
    step(1, 0, 0);
    chk("mode_new", int'(mode), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 19) == 0));

    // ITERATIONS=2 instance: idx 0,1 and done 4 cycles after start.
    do_reset();
    step(1, 1, 0);
    chk("n2_load", int'(load2), 1);
    step(0, 0, 0);
    chk("n2_step0", int'(step2), 1);
    chk("n2_idx0", int'(idx2), 0);
    step(0, 0, 0);
    chk("n2_step1", int'(step2), 1);
    chk("n2_idx1", int'(idx2), 1);
    step(0, 0, 0);
    chk("n2_done", int'(done2), 1);
    chk("n2_rv", int'(rv2), 1);
    chk("n2_mode", int'(mode2), 1);
    step(0, 0, 0);
    chk("n2_idle", int'(busy2) + int'(done2), 0);
    chk("n2_rv_hold", int'(rv2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
